swi_debounce: RTL and testbench

SWI_DEBOUNCE -- requirements
Module: swi_debounce

---
 rtl/swi_debounce.sv | 125 ++++++++++++
 tb/tb_swi_debounce.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/swi_debounce.sv
// -----------------------------------------------------------------------------
// swi_debounce
//
// Debounces NBITS mechanical switch inputs in parallel. Each bit is first
// brought into the clk_2 domain through a two-flop synchronizer (sync1 ->
// sync2). A per-bit counter then measures how many consecutive synchronized
// samples differ from the current debounced level. When DEB_CYCLES such
// samples have been seen, the new level is accepted.
//
// Timing: a raw level change that is stable before rising edge 1 appears on
// swi_db at edge DEB_CYCLES+2. Edges 1 and 2 are spent in the synchronizer.
// Edges 3..DEB_CYCLES+1 count up. The accepting edge is DEB_CYCLES+2.
//
// Parameters
//   NBITS      : number of switch inputs (default 8)
//   DEB_CYCLES : consecutive differing samples needed to accept a level,
//                legal range 2..65535 (default 4)
//
// Ports
//   clk_2    in  1      single clock, rising-edge active
//   reset_n  in  1      asynchronous active-low reset
//   swi_raw  in  NBITS  raw, unsynchronized, bouncing switch levels
//   swi_db   out NBITS  debounced levels (registered)
//   swi_rise out NBITS  one-cycle pulse when swi_db[i] goes 0->1 (registered)
//   swi_fall out NBITS  one-cycle pulse when swi_db[i] goes 1->0 (registered)
//   stable   out 1      combinational. High when every synchronized sample
//                       matches swi_db and every counter is idle.
//
// Configuration macro
//   SWI_DEBOUNCE_EDGE_EN : when defined, swi_rise/swi_fall are generated.
//                          When undefined, they are tied to 0 and no edge
//                          registers exist.
//
// There is no FSM and no handshake. Each bit is an independent
// synchronizer + counter + level register.
// -----------------------------------------------------------------------------
module swi_debounce #(
    parameter int NBITS      = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic             clk_2,
    input  logic             reset_n,
    input  logic [NBITS-1:0] swi_raw,
    output logic [NBITS-1:0] swi_db,
    output logic [NBITS-1:0] swi_rise,
    output logic [NBITS-1:0] swi_fall,
    output logic             stable
);

    // The counter only needs to reach DEB_CYCLES-1. The accepting edge
    // clears it rather than incrementing it.
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic [NBITS-1:0] sync1;
    logic [NBITS-1:0] sync2;
    logic [CW-1:0]    cnt      [NBITS];
    logic [CW-1:0]    cnt_next [NBITS];
    logic [NBITS-1:0] db_next;
    logic             cnt_busy;

    // Per-bit next-state. Bits never share state.
    always_comb begin
        db_next  = swi_db;
        cnt_busy = 1'b0;
        for (int i = 0; i < NBITS; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != swi_db[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    // Enough consecutive differing samples: accept and
                    // restart the count on the same edge.
                    db_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
            // A sample equal to swi_db leaves cnt_next at 0. A glitch
            // therefore discards any partial count.
            if (cnt[i] != '0) begin
                cnt_busy = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= '0;
            sync2  <= '0;
            swi_db <= '0;
            for (int i = 0; i < NBITS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1  <= swi_raw;
            sync2  <= sync1;
            swi_db <= db_next;
            for (int i = 0; i < NBITS; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    // During reset all registers are 0, so this reads 1.
    assign stable = (sync2 == swi_db) && !cnt_busy;

`ifdef SWI_DEBOUNCE_EDGE_EN
    // The pulses are registered from the same next-level that loads swi_db.
    // They are therefore high in exactly the cycle after the changing edge,
    // aligned with the new swi_db value. A bit either rises or falls on a
    // given edge, never both.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            swi_rise <= '0;
            swi_fall <= '0;
        end else begin
            swi_rise <= db_next & ~swi_db;
            swi_fall <= ~db_next & swi_db;
        end
    end
`else
    assign swi_rise = '0;
    assign swi_fall = '0;
`endif

endmodule

// File: tb/tb_swi_debounce.sv
// -----------------------------------------------------------------------------
// tb_swi_debounce
//
// Table-driven bench for swi_debounce (NBITS=8, DEB_CYCLES=4).
//
// Each table row gives one swi_raw value, driven after a falling edge. It
// also gives the expected {swi_db, swi_rise, swi_fall, stable} after the
// following rising edge. Expected values are pushed to exp_q when a row is
// driven. They are popped and compared #1 after the rising edge.
//
// Hand-written sequences cover asynchronous reset, reset release with a
// switch held high, and reset dropped mid-count.
//
// Expected swi_rise/swi_fall are forced to 0 when SWI_DEBOUNCE_EDGE_EN is
// not defined.
// -----------------------------------------------------------------------------
module tb_swi_debounce;

    localparam int NBITS = 8;
    localparam int DEB   = 4;
    localparam int W     = 3 * NBITS + 1;

`ifdef SWI_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic             clk_2   = 1'b0;
    logic             reset_n = 1'b0;
    logic [NBITS-1:0] swi_raw = '0;
    logic [NBITS-1:0] swi_db;
    logic [NBITS-1:0] swi_rise;
    logic [NBITS-1:0] swi_fall;
    logic             stable;

    always #5 clk_2 = ~clk_2;

    swi_debounce #(
        .NBITS      (NBITS),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk_2    (clk_2),
        .reset_n  (reset_n),
        .swi_raw  (swi_raw),
        .swi_db   (swi_db),
        .swi_rise (swi_rise),
        .swi_fall (swi_fall),
        .stable   (stable)
    );

    // ---------------- vector table ----------------
    typedef struct {
        logic [NBITS-1:0] raw;
        logic [NBITS-1:0] db;
        logic [NBITS-1:0] rise;
        logic [NBITS-1:0] fall;
        logic             stb;
        string            tag;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [NBITS-1:0] raw, input logic [NBITS-1:0] db,
                                input logic [NBITS-1:0] rise, input logic [NBITS-1:0] fall,
                                input logic stb, input string tag);
        vec_t v;
        v.raw  = raw;
        v.db   = db;
        v.rise = rise;
        v.fall = fall;
        v.stb  = stb;
        v.tag  = tag;
        vecs.push_back(v);
    endfunction

    // Raw moves from old_v to new_v and is held for DEB+3 edges.
    // After edge 1, only sync1 has moved, so stable is still high.
    // After edges 2..DEB+1, sync2 differs from swi_db, so stable is low.
    // After edge DEB+2, swi_db = new_v and the pulses fire.
    // After edge DEB+3, the pulses are gone.
    function automatic void add_change(input logic [NBITS-1:0] old_v,
                                       input logic [NBITS-1:0] new_v, input string tag);
        for (int e = 1; e <= DEB + 3; e++) begin
            if (e == 1)
                add(new_v, old_v, '0, '0, 1'b1, tag);
            else if (e <= DEB + 1)
                add(new_v, old_v, '0, '0, 1'b0, tag);
            else if (e == DEB + 2)
                add(new_v, new_v, new_v & ~old_v, old_v & ~new_v, 1'b1, tag);
            else
                add(new_v, new_v, '0, '0, 1'b1, tag);
        end
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    function automatic logic [W-1:0] pack_exp(input logic [NBITS-1:0] db,
                                              input logic [NBITS-1:0] rise,
                                              input logic [NBITS-1:0] fall,
                                              input logic stb);
        logic [NBITS-1:0] r;
        logic [NBITS-1:0] f;
        r = EDGE_EN ? rise : '0;
        f = EDGE_EN ? fall : '0;
        return {db, r, f, stb};
    endfunction

    task automatic check_out(input string name);
        logic [W-1:0] exp;
        logic [W-1:0] got;
        if (exp_q.size() == 0) begin
            failures++;
            checks++;
            $display("FAIL %s: scoreboard empty, nothing expected", name);
        end else begin
            exp = exp_q.pop_front();
            got = {swi_db, swi_rise, swi_fall, stable};
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL %s t=%0t: got db=%h rise=%h fall=%h stable=%b, want db=%h rise=%h fall=%h stable=%b",
                         name, $time, got[W-1 -: NBITS], got[2*NBITS -: NBITS], got[NBITS -: NBITS], got[0],
                         exp[W-1 -: NBITS], exp[2*NBITS -: NBITS], exp[NBITS -: NBITS], exp[0]);
            end
        end
    endtask

    // Immediate (clock-independent) check, used around asynchronous reset.
    task automatic expect_now(input logic [NBITS-1:0] db, input logic [NBITS-1:0] rise,
                              input logic [NBITS-1:0] fall, input logic stb, input string name);
        exp_q.push_back(pack_exp(db, rise, fall, stb));
        check_out(name);
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge. Drives one row, checks it after the
    // rising edge, and returns at the next falling edge.
    task automatic step(input vec_t v);
        swi_raw = v.raw;
        exp_q.push_back(pack_exp(v.db, v.rise, v.fall, v.stb));
        @(posedge clk_2);
        #1;
        check_out(v.tag);
        @(negedge clk_2);
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end
        vecs.delete();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Reset state, with no clock edge needed.
        #2;
        expect_now('0, '0, '0, 1'b1, "reset_async");
        repeat (2) @(posedge clk_2);
        #1;
        expect_now('0, '0, '0, 1'b1, "reset_hold");
        @(negedge clk_2);
        reset_n = 1'b1;

        // Idle after release.
        for (int i = 0; i < 3; i++) add(8'h00, 8'h00, '0, '0, 1'b1, "idle");

        // Single bit rise, then fall.
        add_change(8'h00, 8'h01, "rise_b0");
        add_change(8'h01, 8'h00, "fall_b0");

        // Two-cycle glitch on bit 0. sync2 is high for two samples, so the
        // count reaches 2 and is then discarded. No pulses occur.
        add(8'h01, 8'h00, '0, '0, 1'b1, "glitch2");
        add(8'h01, 8'h00, '0, '0, 1'b0, "glitch2");
        add(8'h00, 8'h00, '0, '0, 1'b0, "glitch2");
        add(8'h00, 8'h00, '0, '0, 1'b0, "glitch2");
        add(8'h00, 8'h00, '0, '0, 1'b1, "glitch2");
        add(8'h00, 8'h00, '0, '0, 1'b1, "glitch2");

        // Three-cycle pulse. The count reaches DEB-1 and the sample then
        // reverts, so the pulse is not accepted. The count clears.
        add(8'h01, 8'h00, '0, '0, 1'b1, "glitch3");
        add(8'h01, 8'h00, '0, '0, 1'b0, "glitch3");
        add(8'h01, 8'h00, '0, '0, 1'b0, "glitch3");
        add(8'h00, 8'h00, '0, '0, 1'b0, "glitch3");
        add(8'h00, 8'h00, '0, '0, 1'b0, "glitch3");
        add(8'h00, 8'h00, '0, '0, 1'b1, "glitch3");
        add(8'h00, 8'h00, '0, '0, 1'b1, "glitch3");

        // All bits together.
        add_change(8'h00, 8'hFF, "rise_all");
        add_change(8'hFF, 8'h00, "fall_all");

        // Bit 1 starts two edges after bit 0, so each bit is accepted
        // on its own schedule.
        add(8'h01, 8'h00, '0,    '0, 1'b1, "stagger");
        add(8'h01, 8'h00, '0,    '0, 1'b0, "stagger");
        add(8'h03, 8'h00, '0,    '0, 1'b0, "stagger");
        add(8'h03, 8'h00, '0,    '0, 1'b0, "stagger");
        add(8'h03, 8'h00, '0,    '0, 1'b0, "stagger");
        add(8'h03, 8'h01, 8'h01, '0, 1'b0, "stagger");
        add(8'h03, 8'h01, '0,    '0, 1'b0, "stagger");
        add(8'h03, 8'h03, 8'h02, '0, 1'b1, "stagger");
        add(8'h03, 8'h03, '0,    '0, 1'b1, "stagger");
        add_change(8'h03, 8'h00, "fall_stagger");

        // Mixed pattern.
        add_change(8'h00, 8'h3C, "rise_3c");
        add_change(8'h3C, 8'h00, "fall_3c");
        run_vecs();

        // Switch held at A5 through reset. Release produces no pulses.
        // Acceptance follows a full latency.
        #2;
        reset_n = 1'b0;
        swi_raw = 8'hA5;
        #1;
        expect_now('0, '0, '0, 1'b1, "rst_a5_async");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_2);
            #1;
            expect_now('0, '0, '0, 1'b1, "rst_a5_hold");
        end
        @(negedge clk_2);
        reset_n = 1'b1;
        add_change(8'h00, 8'hA5, "rel_a5");
        run_vecs();

        // Start moving A5 -> FF and drop reset with the counters at 2. The
        // partial count must be lost. After release, acceptance takes a full
        // DEB+2 edges.
        add(8'hFF, 8'hA5, '0, '0, 1'b1, "pre_mid");
        add(8'hFF, 8'hA5, '0, '0, 1'b0, "pre_mid");
        add(8'hFF, 8'hA5, '0, '0, 1'b0, "pre_mid");
        add(8'hFF, 8'hA5, '0, '0, 1'b0, "pre_mid");
        run_vecs();
        #2;
        reset_n = 1'b0;
        #1;
        expect_now('0, '0, '0, 1'b1, "mid_async");
        @(posedge clk_2);
        #1;
        expect_now('0, '0, '0, 1'b1, "mid_hold");
        @(negedge clk_2);
        reset_n = 1'b1;
        add_change(8'h00, 8'hFF, "rel_mid");
        run_vecs();

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // A bit must never rise and fall in the same cycle.
    always @(negedge clk_2) begin
        if (reset_n && ((swi_rise & swi_fall) != '0)) begin
            checks++;
            failures++;
            $display("FAIL rise_fall_overlap: rise=%h fall=%h, want no common bit", swi_rise, swi_fall);
        end
    end

endmodule
